// File: rtl/eaglesong_hash_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : eaglesong_hash_ctrl_if
// Purpose  : Bundles every handshake and datapath bus of the Eaglesong hash
//            controller: message input, absorb-stage datapath, permutation
//            core handshake, digest output and the error pulse.
// Modports : master - the controller (sequences the sponge datapath)
//            slave  - its environment (message source, absorb stage,
//                     permutation core, digest consumer)
// Signals  : in_valid/in_ready/in_data/in_len        message beat
//            abs_state_in/abs_input_val/abs_len/
//            abs_round_num/abs_state_out             absorb stage
//            perm_start/perm_state_o/perm_done/
//            perm_state_i                            permutation core
//            out_valid/out_ready/out_hash            digest
//            err                                     bad length / timeout
// Revision : 1.0 - initial release
// ============================================================================
interface eaglesong_hash_ctrl_if;
   logic                 in_valid;
   logic                 in_ready;
   logic [255:0]         in_data;
   logic [6:0]           in_len;

   logic [7:0][31:0]     abs_state_in;
   logic [255:0]         abs_input_val;
   logic [6:0]           abs_len;
   logic [7:0]           abs_round_num;
   logic [7:0][31:0]     abs_state_out;

   logic                 perm_start;
   logic [511:0]         perm_state_o;
   logic                 perm_done;
   logic [511:0]         perm_state_i;

   logic                 out_valid;
   logic                 out_ready;
   logic [255:0]         out_hash;
   logic                 err;

   modport master (
      input  in_valid, in_data, in_len, abs_state_out, perm_done, perm_state_i, out_ready,
      output in_ready, abs_state_in, abs_input_val, abs_len, abs_round_num,
             perm_start, perm_state_o, out_valid, out_hash, err
   );

   modport slave (
      output in_valid, in_data, in_len, abs_state_out, perm_done, perm_state_i, out_ready,
      input  in_ready, abs_state_in, abs_input_val, abs_len, abs_round_num,
             perm_start, perm_state_o, out_valid, out_hash, err
   );
endinterface
`default_nettype wire

// File: rtl/eaglesong_hash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eaglesong_hash_ctrl
// Purpose  : Sequences one Eaglesong hash of a 1..32-byte message. Latches a
//            message beat, runs one or two absorb rounds through the external
//            combinational absorb stage, hands the 16-word sponge state to
//            the external permutation core over start/done, and presents the
//            256-bit digest (state words 0..7) until the consumer takes it.
// Ports    : clk, rst_n (asynchronous, active-low)
//            bus  - eaglesong_hash_ctrl_if.master (all handshakes/datapath)
//            perf_hashes[31:0], perf_last_lat[15:0] - only when the macro
//            EAGLESONG_CTRL_PERF_EN is defined
// Params   : PERM_TIMEOUT  - cycles to wait for perm_done (0 = no timeout)
//            MAX_LEN_BYTES - largest legal message length (absorb limit)
// Revision : 1.0 - initial release
// ============================================================================
module eaglesong_hash_ctrl #(
   parameter int PERM_TIMEOUT  = 1024,
   parameter int MAX_LEN_BYTES = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   eaglesong_hash_ctrl_if.master     bus
`ifdef EAGLESONG_CTRL_PERF_EN
   ,
   output logic [31:0]               perf_hashes,
   output logic [15:0]               perf_last_lat
`endif
);

   // A message of exactly one rate block pushes the 0x06 delimiter into a
   // second absorb round.
   localparam int RATE_BYTES = 32;
   localparam int TMO_W      = (PERM_TIMEOUT < 2) ? 1 : $clog2(PERM_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ABSORB    = 3'd1,
      PERM_REQ  = 3'd2,
      PERM_WAIT = 3'd3,
      OUT       = 3'd4
   } state_t;

   state_t               st;
   state_t               st_next;
   logic [15:0][31:0]    state;
   logic [255:0]         msg_data;
   logic [6:0]           msg_len;
   logic [7:0]           round;
   logic [TMO_W-1:0]     tmo_cnt;
   logic                 err_q;

   logic                 len_ok;
   logic                 more_rounds;
   logic                 tmo_hit;
   logic                 accept;
   logic                 bad_len;
   logic                 do_absorb;
   logic                 perm_take;
   logic                 round_inc;
   logic                 tmo_inc;
   logic                 tmo_fire;

   assign len_ok      = (bus.in_len != 7'd0) && (bus.in_len <= 7'(MAX_LEN_BYTES));
   assign more_rounds = (msg_len == 7'(RATE_BYTES)) && (round == 8'd0);

   // The counter runs 0..PERM_TIMEOUT-1 across PERM_WAIT cycles; the last
   // value without perm_done is the expiry cycle.
   generate
      if (PERM_TIMEOUT != 0) begin : g_tmo_en
         localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PERM_TIMEOUT - 1);
         assign tmo_hit = (tmo_cnt == TMO_LAST);
      end else begin : g_tmo_off
         assign tmo_hit = 1'b0;
      end
   endgenerate

   // ---------------------------------------------------------------- next state
   always_comb begin
      st_next   = st;
      accept    = 1'b0;
      bad_len   = 1'b0;
      do_absorb = 1'b0;
      perm_take = 1'b0;
      round_inc = 1'b0;
      tmo_inc   = 1'b0;
      tmo_fire  = 1'b0;
      case (st)
         IDLE: begin
            if (bus.in_valid) begin
               if (len_ok) begin
                  accept  = 1'b1;
                  st_next = ABSORB;
               end else begin
                  bad_len = 1'b1;
               end
            end
         end
         ABSORB: begin
            do_absorb = 1'b1;
            st_next   = PERM_REQ;
         end
         PERM_REQ: begin
            st_next = PERM_WAIT;
         end
         PERM_WAIT: begin
            if (bus.perm_done) begin
               perm_take = 1'b1;
               if (more_rounds) begin
                  round_inc = 1'b1;
                  st_next   = ABSORB;
               end else begin
                  st_next = OUT;
               end
            end else if (tmo_hit) begin
               tmo_fire = 1'b1;
               st_next  = IDLE;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         OUT: begin
            if (bus.out_ready) st_next = IDLE;
         end
         default: st_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         state    <= '0;
         msg_data <= '0;
         msg_len  <= '0;
         round    <= '0;
         tmo_cnt  <= '0;
         err_q    <= 1'b0;
      end else begin
         st    <= st_next;
         err_q <= bad_len | tmo_fire;
         if (accept) begin
            msg_data <= bus.in_data;
            msg_len  <= bus.in_len;
            round    <= 8'd0;
         end
         // The absorb stage masks its own rate input in round 0; only the
         // capacity half needs clearing here to start a fresh sponge.
         if (do_absorb) begin
            state[7:0] <= bus.abs_state_out;
            if (round == 8'd0) state[15:8] <= '0;
         end
         if (perm_take) state <= bus.perm_state_i;
         if (tmo_fire)  state <= '0;
         if (round_inc) round <= round + 8'd1;
         if (st == PERM_REQ)  tmo_cnt <= '0;
         else if (tmo_inc)    tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- outputs
   // state is untouched while waiting, so perm_state_o stays stable from
   // PERM_REQ until perm_done and out_hash stays stable through OUT.
   assign bus.in_ready      = (st == IDLE);
   assign bus.perm_start    = (st == PERM_REQ);
   assign bus.out_valid     = (st == OUT);
   assign bus.err           = err_q;
   assign bus.abs_state_in  = state[7:0];
   assign bus.abs_input_val = msg_data;
   assign bus.abs_len       = msg_len;
   assign bus.abs_round_num = round;
   assign bus.perm_state_o  = state;
   assign bus.out_hash      = state[7:0];

`ifdef EAGLESONG_CTRL_PERF_EN
   // lat_cnt holds the number of edges since the accepting edge, so the
   // value captured on the edge entering OUT (plus one) is the count up to
   // the first edge that samples out_valid high.
   logic [15:0] lat_cnt;
   logic [15:0] lat_cnt_inc;

   assign lat_cnt_inc = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt       <= '0;
         perf_hashes   <= '0;
         perf_last_lat <= '0;
      end else begin
         if (accept)                              lat_cnt <= 16'd1;
         else if ((st != IDLE) && (st != OUT))    lat_cnt <= lat_cnt_inc;
         if ((st_next == OUT) && (st != OUT))     perf_last_lat <= lat_cnt_inc;
         if ((st == OUT) && bus.out_ready)        perf_hashes <= perf_hashes + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_eaglesong_hash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eaglesong_hash_ctrl
// Purpose  : Self-checking bench for eaglesong_hash_ctrl. Provides a
//            combinational absorb stub, a permutation stub with selectable
//            delay and behaviour (identity, word-rotate mix, never answer),
//            and a digest reference model built from the padded byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eaglesong_hash_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   eaglesong_hash_ctrl_if bus();

`ifdef EAGLESONG_CTRL_PERF_EN
   logic [31:0] perf_hashes;
   logic [15:0] perf_last_lat;
`endif

   eaglesong_hash_ctrl #(.PERM_TIMEOUT(8), .MAX_LEN_BYTES(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef EAGLESONG_CTRL_PERF_EN
      ,
      .perf_hashes   (perf_hashes),
      .perf_last_lat (perf_last_lat)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;
   int stub_d      = 3;   // permutation delay D
   int stub_mode   = 0;   // 0 identity, 1 mix, 2 never answers
   int perm_starts = 0;
   int hashes_done = 0;
   logic [7:0] round_log[$];

   // ------------------------------------------------------------ stub models
   // Eaglesong absorb: each rate word shifts in, big-endian, only the message
   // bytes and the single 0x06 delimiter; positions past the delimiter add
   // nothing (and no shift).
   function automatic logic [31:0] absorb_word(input logic [255:0] d, input logic [6:0] len,
                                               input logic [7:0] r, input int j);
      logic [31:0] w;
      int idx;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         idx = 32 * int'(r) + 4 * j + k;
         if (idx < int'(len) && idx < 32) w = {w[23:0], d[8*idx +: 8]};
         else if (idx == int'(len))       w = {w[23:0], 8'h06};
      end
      return w;
   endfunction

   function automatic logic [511:0] perm_fn(input logic [511:0] x, input int mode);
      logic [511:0] y;
      if (mode != 1) return x;
      for (int w = 0; w < 16; w++)
         y[32*w +: 32] = x[32*((w + 1) % 16) +: 32] ^ (32'h9E3779B9 * 32'(w + 1));
      return y;
   endfunction

   always_comb begin
      for (int j = 0; j < 8; j++)
         bus.abs_state_out[j] = ((bus.abs_round_num == 8'd0) ? 32'd0 : bus.abs_state_in[j])
                                ^ absorb_word(bus.abs_input_val, bus.abs_len, bus.abs_round_num, j);
   end

   logic         perm_pend = 1'b0;
   int           perm_cnt  = 0;
   logic [511:0] perm_hold = '0;
   assign bus.perm_state_i = perm_hold;

   always @(posedge clk) begin
      bus.perm_done <= 1'b0;
      if (perm_pend) begin
         if (perm_cnt == 1) begin
            bus.perm_done <= 1'b1;
            perm_pend     <= 1'b0;
         end
         perm_cnt <= perm_cnt - 1;
      end
      if (bus.perm_start === 1'b1 && stub_mode != 2) begin
         perm_hold <= perm_fn(bus.perm_state_o, stub_mode);
         if (stub_d <= 1) bus.perm_done <= 1'b1;
         else begin
            perm_pend <= 1'b1;
            perm_cnt  <= stub_d - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (bus.perm_start === 1'b1) begin
         perm_starts++;
         round_log.push_back(bus.abs_round_num);
      end
   end

   // ------------------------------------------------------------ reference
   // Whole-hash model: pad the message, absorb 32-byte blocks, permute.
   function automatic logic [255:0] model_digest(input logic [255:0] d, input int len, input int mode);
      logic [7:0]   stream[$];
      logic [31:0]  s[16];
      logic [31:0]  w;
      logic [511:0] v;
      logic [255:0] r;
      int idx;
      for (int i = 0; i < len; i++) stream.push_back(d[8*i +: 8]);
      stream.push_back(8'h06);
      for (int i = 0; i < 16; i++) s[i] = '0;
      for (int rd = 0; rd < ((len == 32) ? 2 : 1); rd++) begin
         for (int j = 0; j < 8; j++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
               idx = rd * 32 + j * 4 + k;
               if (idx < stream.size()) w = (w << 8) | 32'(stream[idx]);
            end
            s[j] = s[j] ^ w;
         end
         for (int i = 0; i < 16; i++) v[32*i +: 32] = s[i];
         v = perm_fn(v, mode);
         for (int i = 0; i < 16; i++) s[i] = v[32*i +: 32];
      end
      for (int i = 0; i < 8; i++) r[32*i +: 32] = s[i];
      return r;
   endfunction

   function automatic int model_lat(input int len, input int d);
      return (len == 32) ? 2 * d + 5 : d + 3;
   endfunction

   // ------------------------------------------------------------ stimulus helpers
   task automatic send_beat(input logic [255:0] d, input logic [6:0] l, output bit ok);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_len   = l;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   // lat = edges from the accepting edge to the first edge sampling out_valid=1
   task automatic wait_out(output int lat, output bit ok);
      lat = 1;
      ok  = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
         lat++;
      end
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.perm_start) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic release_out();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      hashes_done++;
   endtask

   task automatic rand_msg(output logic [255:0] d, output int len);
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
      len = ($urandom_range(0, 3) == 0) ? 32 : int'($urandom_range(1, 32));
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.in_ready, bus.perm_start, bus.out_valid, bus.err} !== 4'b1000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got rdy/start/ov/err=%b exp 1000",
                  {bus.in_ready, bus.perm_start, bus.out_valid, bus.err});
      end
      vectors++;
      if (bus.out_hash !== 256'd0 || bus.perm_state_o !== 512'd0 || bus.abs_round_num !== 8'd0
          || bus.abs_len !== 7'd0 || bus.abs_input_val !== 256'd0) begin
         miscompares++;
         $display("FAIL reset_regs: hash %h round %0d len %0d, exp all zero",
                  bus.out_hash, bus.abs_round_num, bus.abs_len);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_single_round();
      logic [255:0] d;
      int lat;
      bit ok;
      stub_mode = 0;
      stub_d    = 3;
      d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 8'h00, 24'h636261};
      send_beat(d, 7'd3, ok);
      wait_out(lat, ok);
      vectors++;
      if (!ok || lat != 6) begin
         miscompares++;
         $display("FAIL single_latency: got %0d (seen=%0b) exp 6", lat, ok);
      end
      vectors++;
      if (bus.out_hash !== {224'd0, 32'h61626306}) begin
         miscompares++;
         $display("FAIL single_hash: got %h exp %h", bus.out_hash, {224'd0, 32'h61626306});
      end
      release_out();
   endtask

   task automatic test_two_rounds();
      int lat, p0;
      bit ok;
      stub_mode = 0;
      stub_d    = 3;
      p0 = perm_starts;
      round_log.delete();
      send_beat(256'd0, 7'd32, ok);
      wait_out(lat, ok);
      vectors++;
      if (!ok || lat != 11) begin
         miscompares++;
         $display("FAIL two_latency: got %0d (seen=%0b) exp 11", lat, ok);
      end
      vectors++;
      if (bus.out_hash !== {224'd0, 32'h00000006}) begin
         miscompares++;
         $display("FAIL two_hash: got %h exp %h", bus.out_hash, {224'd0, 32'h6});
      end
      vectors++;
      if (perm_starts - p0 != 2) begin
         miscompares++;
         $display("FAIL two_starts: got %0d exp 2", perm_starts - p0);
      end
      vectors++;
      if (round_log.size() != 2 || round_log[0] !== 8'd0 || round_log[1] !== 8'd1) begin
         miscompares++;
         $display("FAIL two_round_num: got %0d entries exp rounds 0,1", round_log.size());
      end
      release_out();
   endtask

   task automatic test_bad_length();
      int p0;
      p0 = perm_starts;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_len   = 7'd0;
      bus.in_data  = '0;
      @(negedge clk);
      vectors++;
      if (bus.err !== 1'b1 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL badlen_0: got err=%b rdy=%b exp 1 1", bus.err, bus.in_ready);
      end
      bus.in_len = 7'd33;
      @(negedge clk);
      vectors++;
      if (bus.err !== 1'b1 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL badlen_33: got err=%b rdy=%b exp 1 1", bus.err, bus.in_ready);
      end
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      vectors++;
      if (bus.err !== 1'b0 || bus.in_ready !== 1'b1 || perm_starts != p0) begin
         miscompares++;
         $display("FAIL badlen_after: got err=%b rdy=%b starts=%0d exp 0 1 0",
                  bus.err, bus.in_ready, perm_starts - p0);
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] d, h0, exp;
      int len, lat;
      bit ok;
      stub_mode = 1;
      stub_d    = 3;
      rand_msg(d, len);
      exp = model_digest(d, len, 1);
      send_beat(d, 7'(len), ok);
      wait_out(lat, ok);
      h0 = bus.out_hash;
      vectors++;
      if (h0 !== exp) begin
         miscompares++;
         $display("FAIL bp_hash: got %h exp %h", h0, exp);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.out_hash !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got hash %h ov=%b rdy=%b exp held, 1, 0",
                     i, bus.out_hash, bus.out_valid, bus.in_ready);
         end
      end
      release_out();
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_release: got rdy=%b ov=%b exp 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_timeout();
      logic [255:0] d, exp;
      int len, lat;
      bit ok;
      stub_mode = 2;
      rand_msg(d, len);
      send_beat(d, 7'(len), ok);
      wait_start(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL tmo_start: got no perm_start exp one");
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_wait[%0d]: got err=%b rdy=%b exp 0 0", i, bus.err, bus.in_ready);
         end
      end
      @(negedge clk);
      vectors++;
      if (bus.err !== 1'b1 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL tmo_fire: got err=%b rdy=%b exp 1 1", bus.err, bus.in_ready);
      end
      @(negedge clk);
      vectors++;
      if (bus.err !== 1'b0) begin
         miscompares++;
         $display("FAIL tmo_pulse: got err=%b exp 0", bus.err);
      end
      stub_mode = 1;
      stub_d    = int'($urandom_range(1, 8));
      rand_msg(d, len);
      exp = model_digest(d, len, 1);
      send_beat(d, 7'(len), ok);
      wait_out(lat, ok);
      vectors++;
      if (!ok || bus.out_hash !== exp) begin
         miscompares++;
         $display("FAIL tmo_next_hash: got %h exp %h", bus.out_hash, exp);
      end
      release_out();
   endtask

   task automatic test_async_reset();
      logic [255:0] d;
      int len;
      bit ok;
      stub_mode = 0;
      stub_d    = 3;
      rand_msg(d, len);
      send_beat(d, 7'(len), ok);
      wait_start(ok);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.in_ready, bus.perm_start, bus.out_valid, bus.err} !== 4'b1000
          || bus.out_hash !== 256'd0 || bus.abs_len !== 7'd0) begin
         miscompares++;
         $display("FAIL arst_now: got rdy/start/ov/err=%b hash %h exp 1000 and zero",
                  {bus.in_ready, bus.perm_start, bus.out_valid, bus.err}, bus.out_hash);
      end
      hashes_done = 0;
      @(negedge clk) rst_n = 1'b1;
      // The pending stub perm_done lands while the FSM is idle.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vectors++;
         if ({bus.in_ready, bus.perm_start, bus.out_valid, bus.err} !== 4'b1000) begin
            miscompares++;
            $display("FAIL arst_after[%0d]: got rdy/start/ov/err=%b exp 1000",
                     i, {bus.in_ready, bus.perm_start, bus.out_valid, bus.err});
         end
      end
`ifdef EAGLESONG_CTRL_PERF_EN
      vectors++;
      if (perf_hashes !== 32'd0 || perf_last_lat !== 16'd0) begin
         miscompares++;
         $display("FAIL arst_perf: got %0d %0d exp 0 0", perf_hashes, perf_last_lat);
      end
`endif
   endtask

   task automatic test_random();
      logic [255:0] d, exp;
      int len, lat;
      bit ok;
      stub_mode = 1;
      for (int n = 0; n < 20; n++) begin
         stub_d = int'($urandom_range(1, 8));
         rand_msg(d, len);
         exp = model_digest(d, len, 1);
         send_beat(d, 7'(len), ok);
         wait_out(lat, ok);
         vectors++;
         if (!ok || lat != model_lat(len, stub_d)) begin
            miscompares++;
            $display("FAIL rnd_latency[%0d]: got %0d exp %0d (len %0d D %0d)",
                     n, lat, model_lat(len, stub_d), len, stub_d);
         end
         vectors++;
         if (bus.out_hash !== exp || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_hash[%0d]: got %h err=%b exp %h err=0 (len %0d)",
                     n, bus.out_hash, bus.err, exp, len);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         release_out();
`ifdef EAGLESONG_CTRL_PERF_EN
         vectors++;
         if (perf_hashes !== 32'(hashes_done) || perf_last_lat !== 16'(lat)) begin
            miscompares++;
            $display("FAIL rnd_perf[%0d]: got %0d %0d exp %0d %0d",
                     n, perf_hashes, perf_last_lat, hashes_done, lat);
         end
`endif
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] da, db, expb;
      int la, lb, lat;
      bit ok;
      stub_mode = 1;
      stub_d    = int'($urandom_range(1, 8));
      rand_msg(da, la);
      rand_msg(db, lb);
      expb = model_digest(db, lb, 1);
      send_beat(da, 7'(la), ok);
      wait_out(lat, ok);
      // Beat B arrives in the OUT handshake cycle; it must wait one cycle.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = db;
      bus.in_len    = 7'(lb);
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      hashes_done++;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_return: got rdy=%b ov=%b exp 1 0", bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_out(lat, ok);
      vectors++;
      if (!ok || lat != model_lat(lb, stub_d) || bus.out_hash !== expb) begin
         miscompares++;
         $display("FAIL b2b_second: got lat %0d hash %h exp lat %0d hash %h",
                  lat, bus.out_hash, model_lat(lb, stub_d), expb);
      end
      release_out();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_len    = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single_round();
      test_two_rounds();
      test_bad_length();
      test_backpressure();
      test_timeout();
      test_async_reset();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
